// File: rtl/serial_word_collector.sv
// Serial-to-parallel collector: gathers FRAME_BITS bits MSB first under `start`
// and queues finished words in a 2-entry FIFO behind a valid/ready handshake.
module serial_word_collector #(
  parameter int FRAME_BITS = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       serial_in,
  input  logic       abort,
  input  logic       clr_ovf,
  output logic [7:0] word,
  output logic       word_valid,
  input  logic       word_ready,
  output logic       busy,
  output logic       overflow
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [7:0] MASK = 8'((9'd1 << FRAME_BITS) - 9'd1);
  localparam logic [3:0] LAST = 4'(FRAME_BITS - 1);

  state_t     state, state_next;
  logic [3:0] bit_cnt, cnt_next;
  logic [6:0] shreg, shreg_next;
  logic [7:0] push_data;
  logic       frame_push;

  logic [7:0] mem [2];
  logic       rd_ptr, wr_ptr;
  logic [1:0] count;
  logic       pop, do_push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_next;
      bit_cnt <= cnt_next;
      shreg   <= shreg_next;
    end
  end

  // Abort wins over start; bits above FRAME_BITS-1 are masked off at push time.
  always_comb begin
    state_next = state;
    cnt_next   = bit_cnt;
    shreg_next = shreg;
    frame_push = 1'b0;
    push_data  = {shreg, serial_in} & MASK;
    if (abort) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else if (start) begin
      shreg_next = (state == IDLE) ? {6'b0, serial_in} : {shreg[5:0], serial_in};
      if (bit_cnt == LAST) begin
        frame_push = 1'b1;
        cnt_next   = '0;
        state_next = IDLE;
      end else begin
        cnt_next   = bit_cnt + 4'd1;
        state_next = SHIFT;
      end
    end
  end

  assign busy       = (state == SHIFT);
  assign word_valid = (count != 2'd0);
  assign pop        = word_valid & word_ready;
  assign do_push    = frame_push & ((count != 2'd2) | pop);

  // The word register tracks the head entry so it is valid right after a push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= '0;
      word     <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({do_push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (pop) begin
        if (count == 2'd2)
          word <= mem[~rd_ptr];
        else if (do_push)
          word <= push_data;
        else
          word <= '0;
      end else if (do_push && count == 2'd0) begin
        word <= push_data;
      end
      if (frame_push && count == 2'd2 && !pop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

endmodule

// File: doc/serial_word_collector.md
# serial_word_collector

Downstream deserializer for the sequential bit-select serializer. It samples the serial bit stream the serializer produces, MSB first, under the same `start` qualifier. It reassembles each frame of `FRAME_BITS` bits into a parallel word and buffers completed words in a 2-entry FIFO. Words leave through a valid/ready handshake toward the consuming logic.

## Interface
- `FRAME_BITS`, 6: bits per frame, legal 1..8; first received bit lands in word bit `FRAME_BITS-1`.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: bit qualifier; `serial_in` is sampled on every rising `clk` edge where `start`=1.
- `serial_in` input 1: serial data bit.
- `abort` input 1: discards the partial frame in progress.
- `clr_ovf` input 1: clears the sticky `overflow` flag.
- `word` output 8: head-of-FIFO word; bits above `FRAME_BITS-1` are 0.
- `word_valid` output 1: `word` holds a valid entry.
- `word_ready` input 1: consumer accepts `word` on an edge where `word_valid`=1 and `word_ready`=1.
- `busy` output 1: a partial frame is in progress (1..`FRAME_BITS-1` bits held).
- `overflow` output 1: sticky; a completed frame was dropped because the FIFO was full.

## Operation
- Collector FSM has two states.
  - IDLE: `bit_cnt`=0. A `start`=1 edge loads the bit and moves to SHIFT. If `FRAME_BITS`=1, it pushes directly and stays in IDLE.
  - SHIFT: each `start`=1 edge does `shreg <= {shreg, serial_in}` and increments `bit_cnt`. The edge carrying bit number `FRAME_BITS` completes the frame: push `{shreg, serial_in}` zero-extended to 8 bits, clear `bit_cnt`, return to IDLE.
  - `start`=0 edges hold all collector state; gaps inside a frame are legal.
- `abort`=1 has priority over `start`: the FSM goes to IDLE, `bit_cnt`=0, and the bit on that edge is discarded. The FIFO is unaffected.
- FIFO: 2 entries, with read pointer, write pointer and a 2-bit count (0..2).
  - Push happens on frame completion.
  - Pop happens when `word_valid` and `word_ready` are both 1.
  - Push and pop on the same edge are both performed. At count 2 this is legal: the count stays 2 and no overflow occurs.
  - Push at count 2 without a pop drops the new frame and sets `overflow`. Existing entries are untouched.
- `overflow` is cleared by `clr_ovf`. If a set event and `clr_ovf` occur on the same edge, set wins.
- `busy` = (state==SHIFT).
- `word_valid` = (count!=0). `word` = entry at the read pointer, driven as a registered FIFO read.
- Reset, asynchronous: state IDLE, `bit_cnt`=0, `shreg`=0, pointers and count 0, `word`=8'h00, `word_valid`=0, `busy`=0, `overflow`=0.
- Reset asserted mid-frame or with the FIFO non-empty discards everything. No partial word is ever pushed.

## Timing
- Latency: the edge sampling the last bit of a frame writes the FIFO. `word_valid` rises immediately after that edge, with the word stable on `word`.
- Minimum frame time is `FRAME_BITS` cycles. Back-to-back frames with no idle cycle are supported.
- Throughput is one word per `FRAME_BITS` cycles, sustained whenever the consumer holds `word_ready`=1.
- After a pop, the next entry (if any) is presented on `word` after the same edge, so `word_valid` stays high.
- `word` and `word_valid` stay stable while `word_valid`=1 and `word_ready`=0.
- `abort`, `clr_ovf` and `start` are synchronous. Only `rst` is asynchronous; its deassertion is assumed synchronized upstream.

## Test plan
- Reset, then 6 `start` cycles with bits 1,0,1,1,0,1 and `word_ready`=1 → `word`=8'h2D, `word_valid` high exactly one cycle, `busy` high for cycles 1-5.
- Same frame with `start` dropped for 3 cycles after bit 3 → still 8'h2D; `busy` held through the gap.
- `word_ready`=0; send frames 8'h3F, 8'h00, 8'h15 → first two buffered in order, third dropped, `overflow`=1. Then pop twice → 8'h3F, 8'h00, then `word_valid`=0. Pulse `clr_ovf` → `overflow`=0.
- FIFO full; frame completes on the same edge as a pop → no overflow, count stays 2, new word is second in order.
- Assert `abort` after 4 bits, then send a full frame 1,1,0,0,1,0 → single word 8'h32; the aborted bits are not present.
- Assert `rst` asynchronously mid-frame with 1 word buffered → all outputs 0 immediately, before the next clock edge; a following clean frame 0,0,0,0,0,1 → 8'h01.
